// File: rtl/barrel_pkg.sv
// Shared constants and reference rotate helpers for the barrel rotator.
// Left rotation is used only when BARREL_LEFT_ROT_EN is defined.
package barrel_pkg;

  localparam int BARREL_DEFAULT_W = 8;
  localparam int BARREL_MAX_W     = 64;

  // Operates on the low w bits of a 64-bit container.
  function automatic logic [63:0] width_mask(
    input int unsigned w
  );
    logic [63:0] m;
    m = '1;
    if (w < 64) m = m >> (64 - w);
    return m;
  endfunction

  function automatic logic [63:0] ror(
    input logic [63:0] x,
    input int unsigned n,
    input int unsigned w
  );
    logic [63:0] m;
    logic [63:0] v;
    m = width_mask(w);
    v = x & m;
    if (n == 0) return v;
    return ((v >> n) | (v << (w - n))) & m;
  endfunction

  function automatic logic [63:0] rol(
    input logic [63:0] x,
    input int unsigned n,
    input int unsigned w
  );
    logic [63:0] m;
    logic [63:0] v;
    m = width_mask(w);
    v = x & m;
    if (n == 0) return v;
    return ((v << n) | (v >> (w - n))) & m;
  endfunction

endpackage

// File: rtl/barrel_rot_comb.sv
// Combinational log-stage rotator: stage k rotates by 2^k.
// BARREL_LEFT_ROT_EN adds a dir input selecting left rotation.
module barrel_rot_comb
  import barrel_pkg::*;
#(
  parameter  int W  = BARREL_DEFAULT_W,
  localparam int SW = $clog2(W)
) (
  input  logic [W-1:0]  in,
  input  logic [SW-1:0] amt,
`ifdef BARREL_LEFT_ROT_EN
  input  logic          dir,
`endif
  output logic [W-1:0]  out
);

  logic [W-1:0] stg [SW+1];

  assign stg[0] = in;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [W-1:0] r_rot;
`ifdef BARREL_LEFT_ROT_EN
    logic [W-1:0] l_rot;
    assign l_rot = {stg[k][W-S-1:0], stg[k][W-1:W-S]};
`endif
    assign r_rot = {stg[k][S-1:0], stg[k][W-1:S]};
`ifdef BARREL_LEFT_ROT_EN
    assign stg[k+1] = !amt[k] ? stg[k] :
                      dir     ? l_rot  : r_rot;
`else
    assign stg[k+1] = amt[k] ? r_rot : stg[k];
`endif
  end

  assign out = stg[SW];

endmodule

// File: rtl/barrel_wrong_core.sv
// Registered barrel rotator stage: load-and-rotate or recirculate.
// BARREL_LEFT_ROT_EN adds a dir port (1 = rotate left).
module barrel_wrong_core
  import barrel_pkg::*;
#(
  parameter  int data_size = BARREL_DEFAULT_W,
  localparam int SEL_W     = $clog2(data_size)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Load,
  input  logic [SEL_W-1:0]     sel,
`ifdef BARREL_LEFT_ROT_EN
  input  logic                 dir,
`endif
  input  logic [data_size-1:0] data_in,
  output logic [data_size-1:0] data_out
);

  logic [data_size-1:0] rot_in;
  logic [data_size-1:0] rot_out;

  // Recirculation feeds the register back through the same rotator.
  assign rot_in = Load ? data_in : data_out;

  barrel_rot_comb #(
    .W(data_size)
  ) u_rot (
    .in (rot_in),
    .amt(sel),
`ifdef BARREL_LEFT_ROT_EN
    .dir(dir),
`endif
    .out(rot_out)
  );

  always_ff @(posedge clk) begin
    if (reset) data_out <= '0;
    else       data_out <= rot_out;
  end

endmodule

// File: tb/tb_barrel_wrong_core.sv
// Directed self-checking bench for barrel_wrong_core (8-bit).
// Exercises the dir port when BARREL_LEFT_ROT_EN is defined.
module tb_barrel_wrong_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Load = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
`ifdef BARREL_LEFT_ROT_EN
  logic       dir = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  barrel_wrong_core #(.data_size(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .Load    (Load),
    .sel     (sel),
`ifdef BARREL_LEFT_ROT_EN
    .dir     (dir),
`endif
    .data_in (data_in),
    .data_out(data_out)
  );

  // Apply inputs away from the edge, then sample 1ns after it.
  task automatic step(
    input logic       r,
    input logic       ld,
    input logic [2:0] s,
    input logic [7:0] d
  );
    @(negedge clk);
    reset = r; Load = ld; sel = s; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 3'd3, 8'hFF);
      vectors++;
      if (data_out !== 8'h00) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %h want 00", i, data_out);
      end
    end
    step(1'b0, 1'b1, 3'd3, 8'hFF);
    vectors++;
    if (data_out !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_release: got %h want ff", data_out);
    end
  endtask

  task automatic test_load_sweep;
    logic [7:0] exp [8];
    exp = '{8'hB4, 8'h5A, 8'h2D, 8'h96,
            8'h4B, 8'hA5, 8'hD2, 8'h69};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 3'(i), 8'hB4);
      vectors++;
      if (data_out !== exp[i]) begin
        miscompares++;
        $display("FAIL load_sweep sel=%0d: got %h want %h",
                 i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_recirc;
    logic [7:0] exp [5];
    logic [2:0] s   [5];
    exp = '{8'h81, 8'hC0, 8'h60, 8'h30, 8'h30};
    s   = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, i == 0, s[i], 8'h81);
      vectors++;
      if (data_out !== exp[i]) begin
        miscompares++;
        $display("FAIL recirc[%0d]: got %h want %h",
                 i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_wrap;
    step(1'b0, 1'b1, 3'd7, 8'h01);
    vectors++;
    if (data_out !== 8'h02) begin
      miscompares++;
      $display("FAIL wrap_load: got %h want 02", data_out);
    end
    step(1'b0, 1'b0, 3'd7, 8'hEE);
    vectors++;
    if (data_out !== 8'h04) begin
      miscompares++;
      $display("FAIL wrap_recirc: got %h want 04", data_out);
    end
  endtask

  task automatic test_zero_recirc;
    step(1'b1, 1'b0, 3'd0, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 3'(i), 8'hA5);
      vectors++;
      if (data_out !== 8'h00) begin
        miscompares++;
        $display("FAIL zero_recirc sel=%0d: got %h want 00",
                 i, data_out);
      end
    end
  endtask

  task automatic test_midop_reset;
    step(1'b0, 1'b1, 3'd0, 8'h81);
    step(1'b0, 1'b0, 3'd1, 8'h00);
    vectors++;
    if (data_out !== 8'hC0) begin
      miscompares++;
      $display("FAIL midop_pre: got %h want c0", data_out);
    end
    step(1'b1, 1'b0, 3'd1, 8'h00);
    vectors++;
    if (data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL midop_reset: got %h want 00", data_out);
    end
    step(1'b0, 1'b0, 3'd1, 8'hFF);
    vectors++;
    if (data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL midop_after: got %h want 00", data_out);
    end
  endtask

`ifdef BARREL_LEFT_ROT_EN
  task automatic test_left;
    dir = 1'b1;
    step(1'b0, 1'b1, 3'd3, 8'hB4);
    vectors++;
    if (data_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL left_load: got %h want a5", data_out);
    end
    step(1'b0, 1'b0, 3'd1, 8'h00);
    vectors++;
    if (data_out !== 8'h4B) begin
      miscompares++;
      $display("FAIL left_recirc: got %h want 4b", data_out);
    end
    dir = 1'b0;
    step(1'b0, 1'b0, 3'd1, 8'h00);
    vectors++;
    if (data_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL left_dir0: got %h want a5", data_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_sweep();
    test_recirc();
    test_wrap();
    test_zero_recirc();
    test_midop_reset();
`ifdef BARREL_LEFT_ROT_EN
    test_left();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
